// File: rtl/bht_ctrl_pkg.sv
// Shared encodings for the branch history table controller: 2-bit predictor
// counter states and controller FSM states.
package bht_ctrl_pkg;

    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bht_update_fifo.sv
// Synchronous FIFO holding resolved-branch updates; show-ahead read port,
// synchronous reset and clear.
module bht_update_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;
    logic             wipe;

    assign wipe    = rst | clr;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wipe) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !wipe) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit counters, 1-cycle lookup with write
// bypass, queued updates, init sweep. Optional counters under BHT_STATS_EN.
module bht_ctrl
    import bht_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned UPD_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             pred_valid,
    output logic [IDX_W-1:0] pred_idx,
    output logic             pred_taken,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_mispredict,
    output logic             busy
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned FIFO_W  = IDX_W + 1;
    localparam int unsigned CNT_W   = $clog2(UPD_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q;
    ctr_t             tbl_q [ENTRIES];

    logic              clr;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_din, fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic [IDX_W-1:0]  head_idx;
    logic              head_mis;
    ctr_t              head_ctr, head_nxt;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    ctr_t              wr_val;
    ctr_t              lk_ctr;
    logic              lk_taken;

    assign clr       = rst | flush;
    assign fifo_din  = {upd_idx, upd_mispredict};
    assign fifo_push = upd_valid & upd_ready & ~fifo_full;
    assign head_idx  = fifo_dout[FIFO_W-1:1];
    assign head_mis  = fifo_dout[0];
    assign head_ctr  = tbl_q[head_idx];
    assign lk_ctr    = tbl_q[lk_idx];

    bht_update_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Saturating counter step for the update at the FIFO head
    always_comb begin
        head_nxt = head_ctr;
        case (head_ctr)
            STRONGLY_TAKEN:     head_nxt = head_mis ? WEAKLY_TAKEN     : STRONGLY_TAKEN;
            WEAKLY_TAKEN:       head_nxt = head_mis ? WEAKLY_NOT_TAKEN : STRONGLY_TAKEN;
            WEAKLY_NOT_TAKEN:   head_nxt = head_mis ? WEAKLY_TAKEN     : STRONGLY_NOT_TAKEN;
            STRONGLY_NOT_TAKEN: head_nxt = head_mis ? WEAKLY_NOT_TAKEN : STRONGLY_NOT_TAKEN;
            default:            head_nxt = head_ctr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        upd_ready = 1'b0;
        fifo_pop  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = init_ptr_q;
        wr_val    = WEAKLY_TAKEN;
        case (state_q)
            INIT: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (init_ptr_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
            end
            RUN: begin
                upd_ready = (fifo_count < CNT_W'(UPD_DEPTH));
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_en    = 1'b1;
                    wr_idx   = head_idx;
                    wr_val   = head_nxt;
                end
            end
            default: state_d = INIT;
        endcase
        // Reset/flush wins: restart the sweep and suppress any table write
        if (clr) begin
            state_d  = INIT;
            fifo_pop = 1'b0;
            wr_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (clr)                   init_ptr_q <= '0;
        else if (state_q == INIT)  init_ptr_q <= init_ptr_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en) tbl_q[wr_idx] <= wr_val;
    end

    // Lookup sees the entry being written this cycle, not queued updates
    always_comb begin
        lk_taken = lk_ctr[1];
        if (state_q == INIT)                     lk_taken = 1'b1;
        else if (wr_en && (wr_idx == lk_idx))    lk_taken = wr_val[1];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pred_valid <= 1'b0;
            pred_idx   <= '0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= lk_valid;
            pred_idx   <= lk_idx;
            pred_taken <= lk_valid & lk_taken;
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (fifo_pop) begin
            stat_updates <= stat_updates + 32'(1);
            if (head_mis) stat_mispredicts <= stat_mispredicts + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: directed scenarios plus random traffic
// against a queue/array reference model. Stats checks under BHT_STATS_EN.
module tb_bht_ctrl;

    localparam int IDX_W   = 4;
    localparam int DEPTH   = 2;
    localparam int ENTRIES = 16;

    logic       clk, rst, flush, lk_valid, pred_valid, pred_taken;
    logic       upd_valid, upd_ready, upd_mispredict, busy;
    logic [3:0] lk_idx, pred_idx, upd_idx;
`ifdef BHT_STATS_EN
    logic [31:0] stat_updates, stat_mispredicts;
`endif

    int tests = 0;
    int fails = 0;

    bht_ctrl #(.IDX_W(IDX_W), .UPD_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .lk_valid       (lk_valid),
        .lk_idx         (lk_idx),
        .pred_valid     (pred_valid),
        .pred_idx       (pred_idx),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_idx        (upd_idx),
        .upd_mispredict (upd_mispredict),
        .busy           (busy)
`ifdef BHT_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference model: counters as integers 0..3, taken when >= 2
    typedef struct { int idx; bit mis; } upd_t;
    upd_t        q[$];
    upd_t        m_head;
    int          m_tbl [ENTRIES];
    int          m_sweep;
    bit          m_known = 1'b0;
    bit          m_acc;
    bit          m_ready, m_taken;
    bit          e_pv, e_pt;
    int          e_pi;
    int unsigned st_u, st_m;

    function automatic int nxt(input int c, input bit mis);
        bit t;
        t = (c >= 2);
        if (!mis)               return t ? 3 : 0;
        if (c == 0 || c == 3)   return t ? 2 : 1;
        return t ? 1 : 2;
    endfunction

    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst || flush) begin
            m_known = 1'b1;
            m_sweep = ENTRIES;
            q.delete();
            for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 2;
            e_pv = 1'b0; e_pi = 0; e_pt = 1'b0;
            st_u = 0; st_m = 0;
        end else if (m_known) begin
            m_ready = (m_sweep == 0) && (q.size() < DEPTH);
            if (m_sweep == 0 && q.size() > 0) begin
                m_head = q.pop_front();
                m_tbl[m_head.idx] = nxt(m_tbl[m_head.idx], m_head.mis);
                st_u++;
                if (m_head.mis) st_m++;
            end
            m_taken = (m_sweep > 0) ? 1'b1 : (m_tbl[lk_idx] >= 2);
            if (upd_valid && m_ready) begin
                q.push_back('{idx: int'(upd_idx), mis: upd_mispredict});
                m_acc = 1'b1;
            end
            if (m_sweep > 0) m_sweep--;
            e_pv = lk_valid;
            e_pi = int'(lk_idx);
            e_pt = lk_valid && m_taken;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("busy", busy, m_sweep > 0);
            check("upd_ready", upd_ready, (m_sweep == 0) && (q.size() < DEPTH));
            check("pred_valid", pred_valid, e_pv);
            if (e_pv) begin
                check("pred_idx", pred_idx, e_pi);
                check("pred_taken", pred_taken, e_pt);
            end
`ifdef BHT_STATS_EN
            check("stat_updates", stat_updates, st_u);
            check("stat_mispredicts", stat_mispredicts, st_m);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick(1);
        end
    endtask

    task automatic lookup(input int idx, input bit exp_taken, input string tag);
        lk_valid = 1'b1;
        lk_idx   = 4'(idx);
        tick(1);
        lk_valid = 1'b0;
        check({tag, "_valid"}, pred_valid, 1);
        check({tag, "_taken"}, pred_taken, exp_taken);
    endtask

    task automatic send_upd(input int idx, input bit mis, output int waited);
        upd_valid      = 1'b1;
        upd_idx        = 4'(idx);
        upd_mispredict = mis;
        waited         = 0;
        do begin
            tick(1);
            waited++;
        end while (!m_acc && waited < 64);
        upd_valid = 1'b0;
        if (!m_acc) begin
            tests++;
            fails++;
            $display("FAIL upd_accept: idx %0d not accepted after %0d cycles", idx, waited);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 64) begin
            n++;
            tick(1);
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d updates still queued after %0d cycles", q.size(), n);
        end
    endtask

    initial begin
        int n, w;
        rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_mispredict = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset_pred_valid", pred_valid, 0);
        check("reset_pred_taken", pred_taken, 0);
        check("reset_upd_ready", upd_ready, 0);
        busy_len(n);
        check("reset_sweep_len", n, 16);
        lookup(5, 1'b1, "lk5_after_init");

        // WT -> WNT -> WT, then a third mispredict -> WNT
        send_upd(3, 1'b1, w);
        send_upd(3, 1'b1, w);
        drain();
        lookup(3, 1'b1, "idx3_two_mis");
        send_upd(3, 1'b1, w);
        drain();
        lookup(3, 1'b0, "idx3_three_mis");

        // Lookup in the same cycle the head update for idx 7 is written
        upd_valid = 1'b1; upd_idx = 4'd7; upd_mispredict = 1'b1;
        tick(1);
        upd_valid = 1'b0;
        lk_valid = 1'b1; lk_idx = 4'd7;
        tick(1);
        lk_valid = 1'b0;
        check("bypass_valid", pred_valid, 1);
        check("bypass_taken", pred_taken, 0);

        // Updates offered during the sweep wait until RUN, then all apply
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("bp_ready_in_init", upd_ready, 0);
        send_upd(8, 1'b1, w);
        check("bp_first_accept_wait", w, 17);
        check("bp_busy_at_accept", busy, 0);
        send_upd(9, 1'b1, w);
        send_upd(10, 1'b1, w);
        drain();
        lookup(8, 1'b0, "bp_idx8");
        lookup(9, 1'b0, "bp_idx9");
        lookup(10, 1'b0, "bp_idx10");

        // Flush with updates in flight, then flush again mid-sweep at ptr 9
        upd_valid = 1'b1; upd_idx = 4'd11; upd_mispredict = 1'b1;
        tick(1);
        upd_idx = 4'd12; flush = 1'b1;
        tick(1);
        flush = 1'b0; upd_valid = 1'b0;
        tick(9);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        busy_len(n);
        check("midsweep_flush_len", n, 16);
        for (int i = 0; i < ENTRIES; i++) lookup(i, 1'b1, $sformatf("after_flush_lk%0d", i));

`ifdef BHT_STATS_EN
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        send_upd(1, 1'b1, w);
        send_upd(2, 1'b0, w);
        send_upd(3, 1'b1, w);
        send_upd(4, 1'b0, w);
        send_upd(5, 1'b0, w);
        drain();
        check("stat_updates_5", stat_updates, 5);
        check("stat_mispredicts_2", stat_mispredicts, 2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("stat_updates_cleared", stat_updates, 0);
        check("stat_mispredicts_cleared", stat_mispredicts, 0);
`endif

        // Random traffic; small index range half the time to force collisions
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 599) == 0);
            flush          = ($urandom_range(0, 249) == 0);
            lk_valid       = ($urandom_range(0, 1) == 1);
            lk_idx         = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            upd_valid      = ($urandom_range(0, 2) != 0);
            upd_idx        = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            upd_mispredict = ($urandom_range(0, 2) == 0);
            tick(1);
        end
        rst = 1'b0; flush = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
